// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: one digit per slot, PWM-gated anodes,
// and display data latched once per frame so a frame never mixes old and new values.
module seven_seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  CLK100MHZ,
    input  logic                  RESET_BTN,
    input  logic [4*DIGITS-1:0]   digits_bcd,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [7:0]            pwm_in,
    output logic [7:0]            SevenSegment,
    output logic [7:0]            SegmentDrivers,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]    div_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [7:0]          pwm_cnt_r;
    logic [4*DIGITS-1:0] shadow_bcd_r;
    logic [DIGITS-1:0]   shadow_dp_r;
    logic [7:0]          shadow_pwm_r;
    logic                loaded_r;
    logic [7:0]          seg_r;
    logic [7:0]          an_r;
    logic                frame_done_r;

    logic                wrap_s;
    logic                frame_end_s;
    logic                capture_s;
    logic                en_s;
    logic                lit_s;
    logic [3:0]          nib_s;
    logic                dp_s;
    logic [7:0]          seg_next_s;
    logic [7:0]          an_next_s;

    // Slot timing, frame boundary and PWM enable
    always_comb begin
        wrap_s      = (div_cnt_r == DIV_LAST);
        frame_end_s = wrap_s && (idx_r == IDX_LAST);
        // The very first edge after reset loads the shadows without a frame pulse
        capture_s   = frame_end_s || !loaded_r;
        en_s        = (shadow_pwm_r == 8'hFF) || (pwm_cnt_r < shadow_pwm_r);
        lit_s       = en_s && (div_cnt_r >= BLANK_END);
    end

    // Select the shadowed digit and decimal point for the active slot
    always_comb begin
        nib_s = 4'h0;
        dp_s  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nib_s = shadow_bcd_r[4*i +: 4];
                dp_s  = shadow_dp_r[i];
            end else begin
                nib_s = nib_s;
                dp_s  = dp_s;
            end
        end
    end

    // Next cathode and anode patterns, registered below
    always_comb begin
        seg_next_s = loaded_r ? {~dp_s, seg_decode(nib_s)} : 8'hFF;
        an_next_s  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            an_next_s[i] = ~(lit_s && (i < DIGITS) && (idx_r == IDX_W'(i)));
        end
    end

    // Counters, shadow capture and output registers
    always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
        if (!RESET_BTN) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            pwm_cnt_r    <= 8'h00;
            shadow_bcd_r <= {(4*DIGITS){1'b0}};
            shadow_dp_r  <= {DIGITS{1'b0}};
            shadow_pwm_r <= 8'h00;
            loaded_r     <= 1'b0;
            seg_r        <= 8'hFF;
            an_r         <= 8'hFF;
            frame_done_r <= 1'b0;
        end else begin
            div_cnt_r <= wrap_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
            pwm_cnt_r <= wrap_s ? 8'h00 : pwm_cnt_r + 8'h01;
            if (wrap_s) begin
                idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            if (capture_s) begin
                shadow_bcd_r <= digits_bcd;
                shadow_dp_r  <= dp_mask;
                shadow_pwm_r <= pwm_in;
            end else begin
                shadow_bcd_r <= shadow_bcd_r;
                shadow_dp_r  <= shadow_dp_r;
                shadow_pwm_r <= shadow_pwm_r;
            end
            loaded_r     <= 1'b1;
            seg_r        <= seg_next_s;
            an_r         <= an_next_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign SevenSegment   = seg_r;
    assign SegmentDrivers = an_r;
    assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: expected slots are queued from a
// model of the decode table and compared as each scanned slot appears.
module tb_seven_seg_scan_driver;

    localparam int EXP_LOW = 8 - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_bcd = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [7:0]  pwm_in = 8'h00;
    logic [7:0]  seg, an;
    logic        fd;

    logic [15:0] digits2 = 16'h0000;
    logic [3:0]  dp2 = 4'h0;
    logic [7:0]  pwm2 = 8'd128;
    logic [7:0]  seg2, an2;
    logic        fd2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        int         fd;
    } slot_t;
    slot_t sb_q[$];

    seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) u_dut (
        .CLK100MHZ(clk), .RESET_BTN(rst_n), .digits_bcd(digits_bcd), .dp_mask(dp_mask),
        .pwm_in(pwm_in), .SevenSegment(seg), .SegmentDrivers(an), .frame_done(fd)
    );

    seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(512), .BLANK_CYC(2)) u_dut512 (
        .CLK100MHZ(clk), .RESET_BTN(rst_n), .digits_bcd(digits2), .dp_mask(dp2),
        .pwm_in(pwm2), .SevenSegment(seg2), .SegmentDrivers(an2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp);
        slot_t e;
        for (int d = 0; d < 4; d++) begin
            e.an  = ~(8'h01 << d);
            e.seg = {~dp[d], model_seg(bcd[4*d +: 4])};
            e.fd  = (d == 3) ? 1 : 0;
            sb_q.push_back(e);
        end
    endtask

    // Waits for the next lit slot and reports what it looked like; no judging here.
    task automatic collect_slot(output logic [7:0] a, output logic [7:0] s, output int lowc,
                                output int fdc, output bit stable, output bit bad, output bit tmo);
        int n;
        a = 8'hFF; s = 8'h00; lowc = 0; fdc = 0; stable = 1'b1; bad = 1'b0; tmo = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (fd) fdc++;
            n++;
        end while (an == 8'hFF && n < 64);
        if (an == 8'hFF) begin
            tmo = 1'b1;
        end else begin
            a = an; s = seg; n = 0;
            while (an != 8'hFF && n < 64) begin
                lowc++;
                if ($countones(~an) != 1 || an != a) bad = 1'b1;
                if (seg != s) stable = 1'b0;
                @(negedge clk);
                if (fd) fdc++;
                n++;
            end
            if (n >= 64) tmo = 1'b1;
        end
    endtask

    task automatic test_reset();
        digits_bcd = 16'h1234; dp_mask = 4'b0100; pwm_in = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", fd); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL post_rel_seg got %h want ff", seg); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL post_rel_an1 got %h want ff", an); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL first_capture_fd got %b want 0", fd); end
        @(negedge clk);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL post_rel_an2 got %h want ff", an); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL first_capture_fd2 got %b want 0", fd); end
    endtask

    task automatic test_scan();
        slot_t e; logic [7:0] a, s; int lowc, fdc; bit st, bad, tmo;
        push_frame(16'h1234, 4'b0100);
        push_frame(16'h1234, 4'b0100);
        for (int i = 0; i < 8; i++) begin
            e = sb_q.pop_front();
            collect_slot(a, s, lowc, fdc, st, bad, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL scan_timeout slot %0d", i); end
            checks++; if (a !== e.an) begin errors++; $display("FAIL scan_anode slot %0d got %b want %b", i, a, e.an); end
            checks++; if (s !== e.seg) begin errors++; $display("FAIL scan_seg slot %0d got %b want %b", i, s, e.seg); end
            checks++; if (lowc !== EXP_LOW) begin errors++; $display("FAIL scan_lowcnt slot %0d got %0d want %0d", i, lowc, EXP_LOW); end
            checks++; if (fdc !== e.fd) begin errors++; $display("FAIL scan_fd slot %0d got %0d want %0d", i, fdc, e.fd); end
            checks++; if (st !== 1'b1 || bad !== 1'b0) begin errors++; $display("FAIL scan_onehot slot %0d stable %b bad %b want 1 0", i, st, bad); end
        end
    endtask

    task automatic test_midframe();
        slot_t e; logic [7:0] a, s; int lowc, fdc; bit st, bad, tmo;
        push_frame(16'h1234, 4'b0100);
        push_frame(16'h5678, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin digits_bcd = 16'h5678; dp_mask = 4'b0001; end
            e = sb_q.pop_front();
            collect_slot(a, s, lowc, fdc, st, bad, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL mid_timeout slot %0d", i); end
            checks++; if (a !== e.an) begin errors++; $display("FAIL mid_anode slot %0d got %b want %b", i, a, e.an); end
            checks++; if (s !== e.seg) begin errors++; $display("FAIL mid_seg slot %0d got %b want %b", i, s, e.seg); end
            checks++; if (fdc !== e.fd) begin errors++; $display("FAIL mid_fd slot %0d got %0d want %0d", i, fdc, e.fd); end
            checks++; if (st !== 1'b1 || bad !== 1'b0) begin errors++; $display("FAIL mid_onehot slot %0d stable %b bad %b want 1 0", i, st, bad); end
        end
    endtask

    task automatic test_blank_digits();
        slot_t e; logic [7:0] a, s; int lowc, fdc; bit st, bad, tmo;
        digits_bcd = 16'hFEDA; dp_mask = 4'b1010;
        push_frame(16'h5678, 4'b0001);
        push_frame(16'hFEDA, 4'b1010);
        for (int i = 0; i < 8; i++) begin
            e = sb_q.pop_front();
            collect_slot(a, s, lowc, fdc, st, bad, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL blank_timeout slot %0d", i); end
            checks++; if (a !== e.an) begin errors++; $display("FAIL blank_anode slot %0d got %b want %b", i, a, e.an); end
            checks++; if (s !== e.seg) begin errors++; $display("FAIL blank_seg slot %0d got %b want %b", i, s, e.seg); end
            checks++; if (lowc !== EXP_LOW) begin errors++; $display("FAIL blank_lowcnt slot %0d got %0d want %0d", i, lowc, EXP_LOW); end
        end
    endtask

    task automatic test_pwm_zero();
        int n; bit any_low;
        pwm_in = 8'h00;
        n = 0;
        do begin @(negedge clk); n++; end while (fd !== 1'b1 && n < 100);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL pwm0_frame_done timeout after %0d cycles", n); end
        any_low = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (an !== 8'hFF) any_low = 1'b1;
        end
        checks++; if (any_low !== 1'b0) begin errors++; $display("FAIL pwm0_anodes got low anode want ff"); end
        pwm_in = 8'hFF;
    endtask

    task automatic test_reset_mid();
        slot_t e; logic [7:0] a, s; int lowc, fdc; bit st, bad, tmo; int n;
        n = 0;
        do begin @(negedge clk); n++; end while (an == 8'hFF && n < 100);
        checks++; if (an == 8'hFF) begin errors++; $display("FAIL rstmid_wait no lit anode in %0d cycles", n); end
        digits_bcd = 16'h9087; dp_mask = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL rstmid_seg got %h want ff", seg); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL rstmid_an got %h want ff", an); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL rstmid_fd got %b want 0", fd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h9087, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            e = sb_q.pop_front();
            collect_slot(a, s, lowc, fdc, st, bad, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rstmid_timeout slot %0d", i); end
            checks++; if (a !== e.an) begin errors++; $display("FAIL rstmid_anode slot %0d got %b want %b", i, a, e.an); end
            checks++; if (s !== e.seg) begin errors++; $display("FAIL rstmid_seg slot %0d got %b want %b", i, s, e.seg); end
            checks++; if (fdc !== e.fd) begin errors++; $display("FAIL rstmid_fd slot %0d got %0d want %0d", i, fdc, e.fd); end
        end
    endtask

    task automatic test_pwm_half();
        int n, lowc;
        int nonblank = 4 * (512 - 2);
        n = 0;
        do begin @(negedge clk); n++; end while (fd2 !== 1'b1 && n < 3000);
        checks++; if (fd2 !== 1'b1) begin errors++; $display("FAIL pwm128_frame_done timeout after %0d cycles", n); end
        lowc = 0;
        repeat (4 * 512) begin
            @(negedge clk);
            if (an2 != 8'hFF) lowc++;
        end
        checks++;
        if (lowc * 100 < 49 * nonblank || lowc * 100 > 51 * nonblank) begin
            errors++; $display("FAIL pwm128_duty got %0d low of %0d non-blank, want 50%% +/-1%%", lowc, nonblank);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_blank_digits();
        test_pwm_zero();
        test_reset_mid();
        test_pwm_half();
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d entries want 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
